// File: rtl/full_xor_pipe.sv
// full_xor_pipe: refreshes N_SHARES Boolean shares with fresh randomness in
// log2(N_SHARES) butterfly layers, then registers the XOR of all shares.
// Valid/ready pipeline with collapsing bubbles, global enable, flush and
// asynchronous active-low reset.
module full_xor_pipe #(
  parameter int unsigned K_WIDTH  = 32,
  parameter int unsigned N_SHARES = 8,
  parameter int unsigned PIPE     = 1,
  localparam int unsigned LAYERS  = $clog2(N_SHARES),
  localparam int unsigned RANDNUM = LAYERS * N_SHARES / 2,
  localparam int unsigned NSTG    = ((PIPE != 0) ? LAYERS : 1) + 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ena,
  input  logic                         flush,
  input  logic                         i_vld,
  output logic                         i_rdy,
  input  logic [K_WIDTH*N_SHARES-1:0]  i_x,
  input  logic [K_WIDTH*RANDNUM-1:0]   rnd,
  output logic [K_WIDTH-1:0]           o_z,
  output logic                         o_vld,
  input  logic                         o_rdy
);

  localparam int unsigned SW   = K_WIDTH * N_SHARES;      // one full share set
  localparam int unsigned LW   = K_WIDTH * N_SHARES / 2;  // rnd words of one layer
  localparam int unsigned LAST = NSTG - 1;                // output stage index

  if (!(N_SHARES == 2 || N_SHARES == 4 || N_SHARES == 8 || N_SHARES == 16 ||
        N_SHARES == 32)) begin : g_bad_shares
    $error("full_xor_pipe: N_SHARES must be a power of two from 2 to 32");
  end

  // Layer l pairs share lo with share lo + 2^l; pair i takes word i of the layer.
  function automatic logic [SW-1:0] refresh_layer(input logic [SW-1:0] x,
                                                  input logic [LW-1:0] r,
                                                  input int unsigned   l);
    logic [SW-1:0] y;
    int unsigned   lo;
    int unsigned   hi;
    y = x;
    for (int unsigned i = 0; i < N_SHARES / 2; i++) begin
      lo = ((i >> l) << (l + 1)) | (i & ((32'd1 << l) - 32'd1));
      hi = lo + (32'd1 << l);
      y[lo*K_WIDTH +: K_WIDTH] = y[lo*K_WIDTH +: K_WIDTH] ^ r[i*K_WIDTH +: K_WIDTH];
      y[hi*K_WIDTH +: K_WIDTH] = y[hi*K_WIDTH +: K_WIDTH] ^ r[i*K_WIDTH +: K_WIDTH];
    end
    return y;
  endfunction

  function automatic logic [SW-1:0] refresh_all(input logic [SW-1:0]              x,
                                                input logic [K_WIDTH*RANDNUM-1:0] r);
    logic [SW-1:0] y;
    y = x;
    for (int unsigned l = 0; l < LAYERS; l++) begin
      y = refresh_layer(y, r[l*LW +: LW], l);
    end
    return y;
  endfunction

  function automatic logic [K_WIDTH-1:0] xor_fold(input logic [SW-1:0] x);
    logic [K_WIDTH-1:0] acc;
    acc = '0;
    for (int unsigned s = 0; s < N_SHARES; s++) begin
      acc = acc ^ x[s*K_WIDTH +: K_WIDTH];
    end
    return acc;
  endfunction

  logic [NSTG-1:0]          v_q;
  logic [NSTG-1:0]          v_d;
  logic [NSTG-1:0]          load;   // stage captures its upstream this cycle
  logic [NSTG-1:0]          drain;  // stage hands its entry on this cycle
  logic [NSTG-1:0]          room;   // stage empty or draining
  logic                     go;
  logic                     clr;
  logic [NSTG-1:0][SW-1:0]  sh_at;  // [0] = i_x, [s+1] = share stage s
  logic [K_WIDTH-1:0]       oz_q;

  assign sh_at[0] = i_x;
  assign clr      = ena & flush;

  // Backward ready chain: a stage has room if empty or its entry moves on.
  always_comb begin
    go    = ena & ~flush & rst_n;
    drain = '0;
    room  = '0;
    load  = '0;
    drain[LAST] = go & v_q[LAST] & o_rdy;
    for (int s = int'(LAST); s >= 1; s--) begin
      room[s]    = ~v_q[s] | drain[s];
      load[s]    = go & v_q[s-1] & room[s];
      drain[s-1] = load[s];
    end
    room[0] = ~v_q[0] | drain[0];
    i_rdy   = go & room[0];
    load[0] = i_vld & i_rdy;
    v_d     = load | (v_q & ~drain);
  end

  // Valid bits: frozen when ena is low, cleared by flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
    end else if (ena) begin
      if (flush) v_q <= '0;
      else       v_q <= v_d;
    end
  end

  if (PIPE != 0) begin : g_pipe
    // Triangular rnd chain: stage l receives the words of layers l..LAYERS-1.
    localparam int unsigned RIN = LW * LAYERS * (LAYERS + 1) / 2;
    logic [RIN-1:0] rin;

    assign rin[LW*LAYERS-1:0] = rnd;

    for (genvar l = 0; l < LAYERS; l++) begin : g_layer
      localparam int unsigned IOFF = LW * (l * (2 * LAYERS - l + 1) / 2);
      localparam int unsigned IW   = LW * (LAYERS - l);
      logic [SW-1:0] sh_q;

      // Share stage l holds the shares after layer l.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sh_q <= '0;
        end else if (clr) begin
          sh_q <= '0;
        end else if (load[l]) begin
          sh_q <= refresh_layer(sh_at[l], rin[IOFF +: LW], l);
        end
      end
      assign sh_at[l+1] = sh_q;

      if (l < LAYERS - 1) begin : g_carry
        logic [IW-LW-1:0] rnd_q;

        // Only the words of later layers travel with the shares.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            rnd_q <= '0;
          end else if (clr) begin
            rnd_q <= '0;
          end else if (load[l]) begin
            rnd_q <= rin[IOFF+LW +: IW-LW];
          end
        end
        assign rin[IOFF+IW +: IW-LW] = rnd_q;
      end
    end
  end else begin : g_flat
    logic [SW-1:0] sh_q;

    // All layers applied combinationally ahead of a single share stage.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sh_q <= '0;
      end else if (clr) begin
        sh_q <= '0;
      end else if (load[0]) begin
        sh_q <= refresh_all(sh_at[0], rnd);
      end
    end
    assign sh_at[1] = sh_q;
  end

  // Output stage: XOR of the fully refreshed shares.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oz_q <= '0;
    end else if (clr) begin
      oz_q <= '0;
    end else if (load[LAST]) begin
      oz_q <= xor_fold(sh_at[LAST]);
    end
  end

  assign o_z   = oz_q;
  assign o_vld = v_q[LAST];

endmodule
